// File: rtl/mdpx_serial_config_engine_if.sv
// Request/acknowledge bus and Medipix serial pins of the configuration engine.
interface mdpx_serial_config_engine_if #(
   parameter int NUM_CH   = 8,
   parameter int MAX_BITS = 256,
   parameter int LEN_W    = 9
);
   logic [NUM_CH-1:0]          In_Req;
   logic [NUM_CH*MAX_BITS-1:0] In_Data;
   logic [NUM_CH*LEN_W-1:0]    In_Len;
   logic [NUM_CH-1:0]          Out_Ack;
   logic                       Out_Done;
   logic                       Out_Busy;
   logic [3:0]                 Out_Ch;
   logic                       Out_Clk_Mdpx;
   logic                       Out_Data_Mdpx;
   logic                       Out_En_Mdpx;

   // Requester side (decoders) drives words and pulses.
   modport master (
      output In_Req, In_Data, In_Len,
      input  Out_Ack, Out_Done, Out_Busy, Out_Ch,
      input  Out_Clk_Mdpx, Out_Data_Mdpx, Out_En_Mdpx
   );

   // Engine side.
   modport slave (
      input  In_Req, In_Data, In_Len,
      output Out_Ack, Out_Done, Out_Busy, Out_Ch,
      output Out_Clk_Mdpx, Out_Data_Mdpx, Out_En_Mdpx
   );
endinterface

// File: rtl/mdpx_serial_config_engine.sv
// Round-robin arbiter plus serialiser for Medipix configuration words.
// Each granted word is shifted out with a divided serial clock, followed
// by a forced idle gap. All chip-facing outputs come straight from flops.
module mdpx_serial_config_engine #(
   parameter int NUM_CH     = 8,
   parameter int MAX_BITS   = 256,
   parameter int LEN_W      = 9,
   parameter int CLK_DIV    = 2,
   parameter int GAP_CYCLES = 4,
   parameter int LSB_FIRST  = 0
) (
   input logic In_Clk,
   input logic In_Reset,
   mdpx_serial_config_engine_if.slave bus
);
   localparam int CH_IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
   localparam int DIV_W = $clog2(2 * CLK_DIV);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BITS);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

   state_t              state_q, state_d;
   logic [NUM_CH-1:0]   pend_q, pend_d;
   logic [3:0]          ptr_q, ptr_d;
   logic [3:0]          ch_q, ch_d;
   logic [MAX_BITS-1:0] sreg_q, sreg_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [LEN_W-1:0]    bitcnt_q, bitcnt_d;
   logic [DIV_W-1:0]    divcnt_q, divcnt_d;
   logic [GAP_W-1:0]    gapcnt_q, gapcnt_d;
   logic [NUM_CH-1:0]   ack_q, ack_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic                mclk_q, mclk_d;
   logic                mdat_q, mdat_d;
   logic                men_q, men_d;

   logic [MAX_BITS-1:0] word_arr [NUM_CH];
   logic [LEN_W-1:0]    len_arr  [NUM_CH];
   logic [CH_IW-1:0]    ch_idx;
   logic [LEN_W-1:0]    len_clip;

   // Unpack the flattened per-channel words and lengths.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign word_arr[gi] = bus.In_Data[gi*MAX_BITS +: MAX_BITS];
      assign len_arr[gi]  = bus.In_Len[gi*LEN_W +: LEN_W];
   end

   // In LOAD, ch_q already holds the granted channel.
   assign ch_idx   = ch_q[CH_IW-1:0];
   assign len_clip = (len_arr[ch_idx] > MAX_LEN) ? MAX_LEN : len_arr[ch_idx];

   // Next-state logic: arbitration, frame sequencing and next pin values.
   always_comb begin
      logic             found;
      logic [CH_IW-1:0] gnt;
      logic [CH_IW-1:0] cand;
      state_d  = state_q;
      pend_d   = pend_q | bus.In_Req;
      ptr_d    = ptr_q;
      ch_d     = ch_q;
      sreg_d   = sreg_q;
      idx_d    = idx_q;
      bitcnt_d = bitcnt_q;
      divcnt_d = divcnt_q;
      gapcnt_d = gapcnt_q;
      ack_d    = '0;
      done_d   = 1'b0;
      found    = 1'b0;
      gnt      = '0;
      cand     = '0;
      case (state_q)
         S_IDLE: begin
            for (int k = 0; k < NUM_CH; k++) begin
               cand = CH_IW'((int'(ptr_q) + k) % NUM_CH);
               if (!found && pend_q[cand]) begin
                  found = 1'b1;
                  gnt   = cand;
               end
            end
            if (found) begin
               state_d     = S_LOAD;
               ch_d        = 4'(gnt);
               ack_d[gnt]  = 1'b1;
               // A fresh pulse in the grant cycle re-arms the channel.
               pend_d[gnt] = bus.In_Req[gnt];
               ptr_d       = (int'(gnt) == NUM_CH - 1) ? 4'd0 : 4'(int'(gnt) + 1);
            end
         end
         S_LOAD: begin
            sreg_d = word_arr[ch_idx];
            if (len_clip == '0) begin
               state_d  = S_GAP;
               gapcnt_d = '0;
            end else begin
               state_d  = S_SHIFT;
               bitcnt_d = len_clip;
               divcnt_d = '0;
               idx_d    = (LSB_FIRST != 0) ? '0 : IDX_W'(len_clip - LEN_W'(1));
            end
         end
         S_SHIFT: begin
            if (divcnt_q == DIV_LAST) begin
               if (bitcnt_q == LEN_W'(1)) begin
                  state_d  = S_GAP;
                  gapcnt_d = '0;
               end else begin
                  bitcnt_d = bitcnt_q - LEN_W'(1);
                  divcnt_d = '0;
                  idx_d    = (LSB_FIRST != 0) ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
               end
            end else begin
               divcnt_d = divcnt_q + DIV_W'(1);
            end
         end
         default: begin
            if (gapcnt_q == GAP_LAST) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               gapcnt_d = gapcnt_q + GAP_W'(1);
            end
         end
      endcase
      // Pins follow the state being entered so they stay flop-driven.
      busy_d = (state_d != S_IDLE);
      men_d  = (state_d == S_SHIFT);
      mclk_d = men_d && (divcnt_d >= DIV_HALF);
      mdat_d = men_d && sreg_d[idx_d];
   end

   // Single state register for the FSM, datapath and all outputs.
   always_ff @(posedge In_Clk) begin
      if (In_Reset) begin
         state_q  <= S_IDLE;
         pend_q   <= '0;
         ptr_q    <= '0;
         ch_q     <= '0;
         sreg_q   <= '0;
         idx_q    <= '0;
         bitcnt_q <= '0;
         divcnt_q <= '0;
         gapcnt_q <= '0;
         ack_q    <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         mclk_q   <= 1'b0;
         mdat_q   <= 1'b0;
         men_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         ptr_q    <= ptr_d;
         ch_q     <= ch_d;
         sreg_q   <= sreg_d;
         idx_q    <= idx_d;
         bitcnt_q <= bitcnt_d;
         divcnt_q <= divcnt_d;
         gapcnt_q <= gapcnt_d;
         ack_q    <= ack_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         mclk_q   <= mclk_d;
         mdat_q   <= mdat_d;
         men_q    <= men_d;
      end
   end

   assign bus.Out_Ack       = ack_q;
   assign bus.Out_Done      = done_q;
   assign bus.Out_Busy      = busy_q;
   assign bus.Out_Ch        = ch_q;
   assign bus.Out_Clk_Mdpx  = mclk_q;
   assign bus.Out_Data_Mdpx = mdat_q;
   assign bus.Out_En_Mdpx   = men_q;
endmodule

// File: doc/mdpx_serial_config_engine.md
Name: mdpx_serial_config_engine

Overview:
- Parametrised successor to the single-purpose OMR/DAC senders behind the Medipix bridge.
- Accepts up to NUM_CH configuration-word requests (OMR, left/right DAC, CTPR, counter loads, ...).
- Arbitrates them round-robin and serialises the granted word onto the Medipix serial port (clock, data, enable) with programmable bit length, bit order and clock divide.
- Sits between the Decoder_Parametros/Decoder_Dacs outputs and the chip pins; replaces the per-register sig_*_OMR/LD/RD/... paths with one engine.

Parameters:
NUM_CH, 8, number of request channels (1..16)
MAX_BITS, 256, width of each channel's data word; longest frame
LEN_W, 9, width of each length field; must satisfy 2^LEN_W > MAX_BITS
CLK_DIV, 2, In_Clk cycles per Mdpx clock half-period (>=1)
GAP_CYCLES, 4, idle In_Clk cycles forced between frames (>=1)
LSB_FIRST, 0, 0 = bit [len-1] sent first; 1 = bit [0] sent first

Ports:
In_Clk  in  1  system clock; all logic on rising edge
In_Reset  in  1  synchronous, active-high reset
In_Req  in  NUM_CH  one-cycle request pulse per channel
In_Data  in  NUM_CH*MAX_BITS  flattened words; channel i at [i*MAX_BITS +: MAX_BITS]; sampled in LOAD
In_Len  in  NUM_CH*LEN_W  flattened bit counts; channel i at [i*LEN_W +: LEN_W]; sampled in LOAD
Out_Ack  out  NUM_CH  one-hot, one-cycle pulse: channel word latched
Out_Done  out  1  one-cycle pulse: frame plus gap finished
Out_Busy  out  1  high in any state except IDLE
Out_Ch  out  4  index of channel being served; held after frame
Out_Clk_Mdpx  out  1  serial clock to chip
Out_Data_Mdpx  out  1  serial data to chip
Out_En_Mdpx  out  1  frame enable, high while bits are shifted

Behaviour:
- Reset (synchronous, active-high, any state including mid-frame): all outputs 0, pending cleared, state IDLE, round-robin pointer = 0. A frame in progress is aborted with no Out_Done.
- Pending bits: pend[i] is set on the edge after In_Req[i]=1 and cleared on the edge entering LOAD for channel i.
  - A request to an already-pending channel merges; it produces no second frame.
  - A request to the channel currently in SHIFT or GAP re-arms it for one more frame.
- FSM states:
  - IDLE: if any pend bit is set, grant the first set bit at or after ptr (wrapping modulo NUM_CH), then go to LOAD. Set ptr = grant+1, wrapping NUM_CH-1 to 0.
  - LOAD (1 cycle):
    - Out_Ack[grant]=1, Out_Ch=grant.
    - Latch word into a MAX_BITS shift register.
    - Latch len = min(In_Len, MAX_BITS).
    - If len==0, go to GAP; else go to SHIFT with bitcnt=len and divcnt=0.
  - SHIFT:
    - Each bit occupies 2*CLK_DIV cycles. Out_Clk_Mdpx=0 for the first CLK_DIV cycles and 1 for the next CLK_DIV.
    - Out_Data_Mdpx changes only at the start of a bit (clock low), so the chip samples on the rising edge.
    - Out_En_Mdpx=1 throughout.
    - After the last bit's high phase, go to GAP.
  - GAP: Out_En_Mdpx=0, Out_Clk_Mdpx=0, Out_Data_Mdpx=0 for GAP_CYCLES cycles, then IDLE with a one-cycle Out_Done pulse on the IDLE-entry cycle.
- Bit order:
  - LSB_FIRST=0: bits len-1 down to 0.
  - LSB_FIRST=1: bits 0 up to len-1.
  - Bits at or above len are never driven.
- Latency: req in cycle 0 → pending in cycle 1 → LOAD/Ack in cycle 2 → first SHIFT cycle (Out_En=1) in cycle 3. Applies only if the engine was idle.
- Frame duration: Out_En high for exactly len*2*CLK_DIV cycles. Busy lasts 1 + len*2*CLK_DIV + GAP_CYCLES cycles.
- Outputs are registered (no combinational path from inputs to the Mdpx pins).
- In_Data/In_Len may change after Ack with no effect on the current frame.

Test Plan:
1. Reset, then req ch0 with len=8, data=0xA5, defaults (MSB first, CLK_DIV=2) → Ack[0] in cycle 2; En high cycles 3..34 (32 cycles); data bits 1,0,1,0,0,1,0,1; 8 rising clock edges; Done 4 cycles after En falls.
2. LSB_FIRST=1, ch3 len=3, data=0b110 → serial sequence 0,1,1; Out_Ch=3.
3. Same-cycle requests on ch1, ch5, ch6 with ptr=0 → service order 1,5,6. Then new reqs on ch1 and ch6 during ch6's frame → order 1 then 6 (round robin continues from ptr=7, wrapping to 0).
4. Boundaries: len=0 → Ack, no En, Done after GAP. len=300 with MAX_BITS=256 → exactly 256 bits clocked. len=1 → one clock pulse.
5. Assert In_Reset mid-SHIFT (bit 5 of 48) → next cycle all outputs 0, Busy=0, no Done. A request 1 cycle after reset release is served with the normal 3-cycle latency.
6. Duplicate pulse on pending ch2 before grant → exactly one ch2 frame. Pulse on ch2 during ch2's own SHIFT → second ch2 frame follows after GAP.
